// File: rtl/gates4_result_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gates4_result_checker                                         |
// | Purpose  : Scoreboard for a 4-input AND/OR/XOR DUT. Compares DUT outputs |
// |            against reference gates, keeps saturating per-output and     |
// |            total mismatch counters, a sample counter and a run timer.    |
// | Options  : GATES4_CHK_FIRST_ERR_EN - capture ts of first mismatch per    |
// |            category (and, or, xor, any); otherwise first_* read 0.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gates4_result_checker #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             smp_valid_i,
  input  logic [3:0]       din_i,
  input  logic             dut_and_i,
  input  logic             dut_or_i,
  input  logic             dut_xor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_and_o,
  output logic [CNT_W-1:0] err_or_o,
  output logic [CNT_W-1:0] err_xor_o,
  output logic [CNT_W-1:0] err_total_o,
  output logic [CNT_W-1:0] smp_cnt_o,
  output logic [TS_W-1:0]  first_and_o,
  output logic [TS_W-1:0]  first_or_o,
  output logic [TS_W-1:0]  first_xor_o,
  output logic [TS_W-1:0]  first_any_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              mismatch_q, mismatch_d;
  logic [CNT_W-1:0]  err_and_q, err_and_d;
  logic [CNT_W-1:0]  err_or_q, err_or_d;
  logic [CNT_W-1:0]  err_xor_q, err_xor_d;
  logic [CNT_W-1:0]  err_total_q, err_total_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d;

  logic exp_and, exp_or, exp_xor;
  logic miss_and, miss_or, miss_xor, miss_any;
  logic accept;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // Reference model and 4-state compare: X/Z on any DUT output is a miss.
  always_comb begin
    exp_and  = &din_i;
    exp_or   = |din_i;
    exp_xor  = ^din_i;
    miss_and = (dut_and_i !== exp_and);
    miss_or  = (dut_or_i  !== exp_or);
    miss_xor = (dut_xor_i !== exp_xor);
    miss_any = miss_and | miss_or | miss_xor;
    accept   = (state_q == S_RUN) && smp_valid_i && !start_i;
  end

  // Next state: start always (re)enters RUN and wins over stop.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && stop_i) begin
      state_d = S_DONE;
    end
  end

  // Next statistics: cleared by start, updated by each accepted sample.
  always_comb begin
    ts_d        = ts_q;
    mismatch_d  = 1'b0;
    err_and_d   = err_and_q;
    err_or_d    = err_or_q;
    err_xor_d   = err_xor_q;
    err_total_d = err_total_q;
    smp_cnt_d   = smp_cnt_q;
    if (start_i) begin
      ts_d        = '0;
      err_and_d   = '0;
      err_or_d    = '0;
      err_xor_d   = '0;
      err_total_d = '0;
      smp_cnt_d   = '0;
    end else begin
      if (state_q == S_RUN) begin
        ts_d = ts_q + TS_ONE;
      end
      if (accept) begin
        smp_cnt_d  = sat_inc(smp_cnt_q);
        mismatch_d = miss_any;
        if (miss_and) err_and_d   = sat_inc(err_and_q);
        if (miss_or)  err_or_d    = sat_inc(err_or_q);
        if (miss_xor) err_xor_d   = sat_inc(err_xor_q);
        if (miss_any) err_total_d = sat_inc(err_total_q);
      end
    end
  end

  // State and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      mismatch_q  <= 1'b0;
      err_and_q   <= '0;
      err_or_q    <= '0;
      err_xor_q   <= '0;
      err_total_q <= '0;
      smp_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      mismatch_q  <= mismatch_d;
      err_and_q   <= err_and_d;
      err_or_q    <= err_or_d;
      err_xor_q   <= err_xor_d;
      err_total_q <= err_total_d;
      smp_cnt_q   <= smp_cnt_d;
    end
  end

  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign mismatch_o  = mismatch_q;
  assign err_and_o   = err_and_q;
  assign err_or_o    = err_or_q;
  assign err_xor_o   = err_xor_q;
  assign err_total_o = err_total_q;
  assign smp_cnt_o   = smp_cnt_q;

`ifdef GATES4_CHK_FIRST_ERR_EN
  // Index order: 0=and, 1=or, 2=xor, 3=any.
  logic [3:0]            cap_q, cap_d;
  logic [3:0][TS_W-1:0]  first_q, first_d;
  logic [3:0]            miss_vec;

  // Latch ts on the first miss of each category, then hold until start.
  always_comb begin
    miss_vec = {miss_any, miss_xor, miss_or, miss_and};
    cap_d    = cap_q;
    first_d  = first_q;
    if (start_i) begin
      cap_d   = '0;
      first_d = '0;
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (miss_vec[i] && !cap_q[i]) begin
          cap_d[i]   = 1'b1;
          first_d[i] = ts_q;
        end
      end
    end
  end

  // Capture flags and first-mismatch timestamps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      first_q <= '0;
    end else begin
      cap_q   <= cap_d;
      first_q <= first_d;
    end
  end

  assign first_and_o = first_q[0];
  assign first_or_o  = first_q[1];
  assign first_xor_o = first_q[2];
  assign first_any_o = first_q[3];
`else
  assign first_and_o = '0;
  assign first_or_o  = '0;
  assign first_xor_o = '0;
  assign first_any_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gates4_result_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gates4_result_checker                                      |
// | Purpose  : Directed self-checking bench for gates4_result_checker. A     |
// |            second instance with CNT_W=4 shares all inputs and is used    |
// |            for saturation. Honours GATES4_CHK_FIRST_ERR_EN.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_gates4_result_checker;

`ifdef GATES4_CHK_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop_i, smp_valid_i;
  logic [3:0]  din_i;
  logic        dut_and_i, dut_or_i, dut_xor_i;

  logic        busy_o, done_o, mismatch_o;
  logic [15:0] err_and_o, err_or_o, err_xor_o, err_total_o, smp_cnt_o;
  logic [31:0] first_and_o, first_or_o, first_xor_o, first_any_o;

  logic        s_busy, s_done, s_mismatch;
  logic [3:0]  s_err_and, s_err_or, s_err_xor, s_err_total, s_smp_cnt;
  logic [31:0] s_first_and, s_first_or, s_first_xor, s_first_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gates4_result_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .smp_valid_i(smp_valid_i), .din_i(din_i),
    .dut_and_i(dut_and_i), .dut_or_i(dut_or_i), .dut_xor_i(dut_xor_i),
    .busy_o(busy_o), .done_o(done_o), .mismatch_o(mismatch_o),
    .err_and_o(err_and_o), .err_or_o(err_or_o), .err_xor_o(err_xor_o),
    .err_total_o(err_total_o), .smp_cnt_o(smp_cnt_o),
    .first_and_o(first_and_o), .first_or_o(first_or_o),
    .first_xor_o(first_xor_o), .first_any_o(first_any_o)
  );

  gates4_result_checker #(.CNT_W(4), .TS_W(32)) u_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .smp_valid_i(smp_valid_i), .din_i(din_i),
    .dut_and_i(dut_and_i), .dut_or_i(dut_or_i), .dut_xor_i(dut_xor_i),
    .busy_o(s_busy), .done_o(s_done), .mismatch_o(s_mismatch),
    .err_and_o(s_err_and), .err_or_o(s_err_or), .err_xor_o(s_err_xor),
    .err_total_o(s_err_total), .smp_cnt_o(s_smp_cnt),
    .first_and_o(s_first_and), .first_or_o(s_first_or),
    .first_xor_o(s_first_xor), .first_any_o(s_first_any)
  );

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d,
                       input logic a, input logic o, input logic x);
    smp_valid_i = v;
    din_i       = d;
    dut_and_i   = a;
    dut_or_i    = o;
    dut_xor_i   = x;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_mism",  mismatch_o, 0);
    chk("rst_smp",   smp_cnt_o, 0);
    chk("rst_total", err_total_o, 0);
    step();
    rst_n = 1'b1;
    // Samples in IDLE are ignored.
    drive(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("idle_smp",  smp_cnt_o, 0);
    chk("idle_busy", busy_o, 0);

    // Sixteen correct samples then stop.
    pulse_start();
    chk("start_busy", busy_o, 1);
    for (int d = 0; d < 16; d++) begin
      logic [3:0] v;
      v = d[3:0];
      drive(1'b1, v, &v, |v, ^v);
      step();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("r31_smp",   smp_cnt_o, 16);
    chk("r31_and",   err_and_o, 0);
    chk("r31_or",    err_or_o, 0);
    chk("r31_xor",   err_xor_o, 0);
    chk("r31_total", err_total_o, 0);
    chk("r31_done",  done_o, 1);
    chk("r31_busy",  busy_o, 0);
    // Failing samples in DONE are ignored.
    drive(1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
    step(); step(); step();
    chk("done_smp",   smp_cnt_o, 16);
    chk("done_total", err_total_o, 0);
    chk("done_mism",  mismatch_o, 0);

    // Single AND failure at ts=5.
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    chk("r32_clr_smp", smp_cnt_o, 0);
    repeat (5) step();
    drive(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("r32_mism",    mismatch_o, 1);
    chk("r32_and",     err_and_o, 1);
    chk("r32_or",      err_or_o, 0);
    chk("r32_xor",     err_xor_o, 0);
    chk("r32_total",   err_total_o, 1);
    chk("r32_f_and",   first_and_o, FE ? 5 : 0);
    chk("r32_f_any",   first_any_o, FE ? 5 : 0);
    chk("r32_f_or",    first_or_o, 0);
    step();
    chk("r32_mism_end", mismatch_o, 0);

    // All three outputs inverted, twice.
    pulse_start();
    chk("r33_clr_tot", err_total_o, 0);
    chk("r33_clr_fa",  first_and_o, 0);
    step(); step();
    drive(1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
    step();
    chk("r33_and",   err_and_o, 1);
    chk("r33_or",    err_or_o, 1);
    chk("r33_xor",   err_xor_o, 1);
    chk("r33_total", err_total_o, 1);
    chk("r33_f_xor", first_xor_o, FE ? 2 : 0);
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("r33_and2",   err_and_o, 2);
    chk("r33_total2", err_total_o, 2);
    chk("r33_f_and2", first_and_o, FE ? 2 : 0);
    chk("r33_f_or2",  first_or_o, FE ? 2 : 0);
    chk("r33_f_any2", first_any_o, FE ? 2 : 0);

    // Into DONE, then start+stop together with a failing sample present.
    stop_i = 1'b1;
    step();
    chk("r35_done", done_o, 1);
    start_i = 1'b1;
    drive(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("r35_busy",  busy_o, 1);
    chk("r35_done0", done_o, 0);
    chk("r35_smp",   smp_cnt_o, 0);
    chk("r35_total", err_total_o, 0);
    chk("r35_mism",  mismatch_o, 0);
    chk("r35_f_any", first_any_o, 0);
    // Sample on the stop cycle counts; next one does not.
    drive(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("stopcyc_smp",  smp_cnt_o, 1);
    chk("stopcyc_done", done_o, 1);
    step();
    chk("afterstop_smp", smp_cnt_o, 1);

    // Saturation on the CNT_W=4 instance.
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (20) step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("r34_s_total", s_err_total, 15);
    chk("r34_s_and",   s_err_and, 15);
    chk("r34_s_smp",   s_smp_cnt, 15);
    chk("r34_s_or",    s_err_or, 0);
    chk("r34_total",   err_total_o, 20);

    // Asynchronous reset mid-RUN.
    pulse_start();
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    chk("r36_pre_total", err_total_o, 3);
    chk("r36_pre_mism",  mismatch_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r36_total", err_total_o, 0);
    chk("r36_and",   err_and_o, 0);
    chk("r36_smp",   smp_cnt_o, 0);
    chk("r36_mism",  mismatch_o, 0);
    chk("r36_busy",  busy_o, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("r36_idle_smp",  smp_cnt_o, 0);
    chk("r36_idle_busy", busy_o, 0);
    chk("r36_idle_done", done_o, 0);
    pulse_start();
    step();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("r36_resume_tot", err_total_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gates4_result_checker.md
GATES4_RESULT_CHECKER -- requirements
Module: gates4_result_checker

Interface
REQ-001 Parameter CNT_W, default 16, width of every mismatch and sample counter.
REQ-002 Parameter TS_W, default 32, width of the cycle timestamp and first-mismatch time registers.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse: clear all statistics and enter RUN.
REQ-006 stop  in  1  one-cycle pulse: freeze the statistics and enter DONE.
REQ-007 smp_valid  in  1  the current din and DUT outputs form a sample.
REQ-008 din  in  4  stimulus vector applied to the gates4 DUT.
REQ-009 dut_and / dut_or / dut_xor  in  1 each  DUT outputs to be checked.
REQ-010 busy  out  1  high while in RUN.
REQ-011 done  out  1  high while in DONE.
REQ-012 mismatch  out  1  registered; high for one cycle after a failing sample.
REQ-013 err_and / err_or / err_xor  out  CNT_W each  per-output mismatch counts.
REQ-014 err_total  out  CNT_W  count of samples with at least one failing output.
REQ-015 smp_cnt  out  CNT_W  count of accepted samples.
REQ-016 first_and / first_or / first_xor / first_any  out  TS_W each  timestamp of the first mismatch of each category.

Function
REQ-017 Expected values: exp_and = AND of din[3:0]; exp_or = OR of din[3:0]; exp_xor = XOR (parity) of din[3:0].
REQ-018 States are IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE on stop.
- DONE->RUN on start.
- All other cases: hold state.
REQ-019 start in any state clears every counter, every first_* register, ts and mismatch in the same edge; start takes priority over stop when both are asserted.
REQ-020 ts is a TS_W counter: reset to 0 on start, incremented every cycle in RUN, wraps modulo 2^TS_W, held in IDLE and DONE.
REQ-021 A sample is accepted only when the state is RUN and smp_valid=1 and start=0. Samples in IDLE or DONE, or in the cycle of start, are ignored.
REQ-022 An accepted sample on the stop cycle is still counted; counting ceases from the next cycle.
REQ-023 For each accepted sample:
- smp_cnt increments by 1.
- Each err_x increments by 1 if dut_x differs from exp_x.
- err_total increments by 1 if any output differs.
REQ-024 Any DUT input that is X or Z counts as a mismatch. Implement the compare as a 4-state inequality (!==).
REQ-025 All counters saturate at 2^CNT_W-1 and do not wrap.
REQ-026 Statistics outputs are registered: an accepted sample is visible on them one cycle after its clk edge. mismatch follows the same one-cycle latency.
REQ-027 busy = (state==RUN); done = (state==DONE). Both are decoded directly from the state register.

Reset
REQ-028 rst_n=0 immediately forces:
- state=IDLE.
- ts, all counters and all first_* registers = 0.
- mismatch, busy and done = 0.
REQ-029 Reset assertion mid-RUN discards all statistics. After rst_n is released the block stays in IDLE until start.

Configuration
REQ-030 Macro GATES4_CHK_FIRST_ERR_EN selects first-mismatch capture.
- Defined: each first_x captures ts at its first mismatch after start and then holds. Its companion capture flag is cleared by start and by reset.
- Undefined: no capture registers exist and all first_* outputs are tied to 0.
- All other behaviour is identical in both builds.

Verification
REQ-031 Reset, start, then 16 valid samples din=0..15 with correct DUT outputs, then stop -> smp_cnt=16, all err=0, done=1, busy=0.
REQ-032 In RUN, at ts=5, din=4'b1111 with dut_and=0 -> next cycle mismatch=1, err_and=1, err_total=1; with _EN defined first_and=5 and first_any=5.
REQ-033 din=4'b0111 with all three DUT outputs inverted -> err_and=err_or=err_xor=1 and err_total=1. A second such sample leaves first_* unchanged.
REQ-034 CNT_W=4, 20 consecutive failing samples -> err_total=15 and err_and=15, saturated; smp_cnt=15.
REQ-035 start and stop in the same cycle while in DONE -> state RUN with all statistics cleared. Samples while in IDLE or DONE leave smp_cnt unchanged.
REQ-036 rst_n pulsed low mid-RUN with err_total=3 -> all outputs 0 asynchronously, state IDLE, and smp_valid samples ignored until start.
